div5_serial: RTL and testbench

Sequential divide-by-5 engine for unsigned dividends, built around the same 5-input residue step as the combinational constant-division cells. It consumes a full dividend through a valid/ready handshake and iterates a radix-4 step, two dividend bits per cycle, MSB first. It produces the quotient and, optionally, the remainder through a second valid/ready handshake. It sits directly upstream of result consumers and downstream of the operand source, and serves as the area-lean alternative to the unrolled combinational divider.

---
 rtl/div5_serial.sv | 124 ++++++++++++
 tb/tb_div5_serial.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div5_serial.sv
// div5_serial: sequential divide-by-5 engine.
// Radix-4 long division, two dividend bits per cycle, MSB first. Each step
// folds the running residue (0..4) with the next two dividend bits into a
// 5-bit value v (0..19), emitting one 2-bit quotient digit and the new residue.
// Optional feature macro: DIV5_REM_OUT_EN adds the out_remainder port.
module div5_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
`ifdef DIV5_REM_OUT_EN
  output logic [2:0]       out_remainder,
`endif
  output logic             busy
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [2:0]       r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [4:0]       step_v;
  logic [1:0]       step_qd;
  logic [2:0]       step_r;
  logic             last_step;

  // One radix-4 residue step: v in 0..19 -> {digit 0..3, residue 0..4}.
  function automatic logic [4:0] div5_step(input logic [4:0] v);
    if (v >= 5'd15)      return {2'd3, 3'(v - 5'd15)};
    else if (v >= 5'd10) return {2'd2, 3'(v - 5'd10)};
    else if (v >= 5'd5)  return {2'd1, 3'(v - 5'd5)};
    else                 return {2'd0, 3'(v)};
  endfunction

  // Residue step datapath on the current residue and top two unconsumed bits.
  always_comb begin
    step_v              = {r_q, shift_q[WIDTH-1:WIDTH-2]};
    {step_qd, step_r}   = div5_step(step_v);
    last_step           = (cnt_q == CW'(HALF - 1));
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    quot_d  = quot_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = in_dividend;
          quot_d  = '0;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        quot_d  = {quot_q[WIDTH-3:0], step_qd};
        shift_d = {shift_q[WIDTH-3:0], 2'b00};
        r_d     = step_r;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      quot_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      quot_q  <= quot_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DIV5_REM_OUT_EN
  logic [2:0] rem_out_q;

  // Capture the final residue on the last step; held until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                rem_out_q <= '0;
    else if (state_q == S_RUN && last_step) rem_out_q <= step_r;
  end

  assign out_remainder = rem_out_q;
`endif

  // Handshake flags decode the state register only.
  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign out_quotient = quot_q;

endmodule

// File: tb/tb_div5_serial.sv
// Scoreboard bench for div5_serial (WIDTH = 32): expected results come from
// plain integer division of each accepted dividend.
module tb_div5_serial;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
`ifdef DIV5_REM_OUT_EN
  logic [2:0]   out_remainder;
`endif
  logic         busy;

  div5_serial #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
`ifdef DIV5_REM_OUT_EN
    .out_remainder(out_remainder),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [2:0]   r;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   burst_mode = 0;
  bit   rand_ready = 0;
  int   prev_acc   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever @(posedge clk) cyc++;

  // Random out_ready during the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Input monitor: every accepted dividend pushes its reference result.
  initial forever begin
    @(negedge clk);
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e.q   = in_dividend / 5;
      e.r   = 3'(in_dividend % 5);
      e.acc = cyc + 1;
      if (burst_mode && prev_acc >= 0) chk("initiation_interval", 64'(e.acc - prev_acc), 18);
      prev_acc = e.acc;
      sb.push_back(e);
      $display("accept  dividend=%0d (cycle %0d)", in_dividend, e.acc);
    end
  end

  // Output monitor: compares every delivered result against the scoreboard.
  initial begin
    bit           seen = 0;
    bit           expect_idle = 0;
    logic [W-1:0] held_q = '0;
`ifdef DIV5_REM_OUT_EN
    logic [2:0]   held_r = '0;
`endif
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        expect_idle = 0;
      end else begin
        chk("busy_is_not_ready", busy, !in_ready);
        chk("residue_le_4", dut.r_q <= 3'd4, 1);
        if (expect_idle) begin
          chk("ready_after_delivery", in_ready, 1);
          expect_idle = 0;
        end
        if (out_valid) begin
          chk("ready_low_in_done", in_ready, 0);
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            if (!seen) begin
              chk("latency", 64'(cyc - sb[0].acc), 16);
              seen = 1;
              held_q = out_quotient;
`ifdef DIV5_REM_OUT_EN
              held_r = out_remainder;
`endif
            end else begin
              chk("quotient_stable", out_quotient, held_q);
`ifdef DIV5_REM_OUT_EN
              chk("remainder_stable", out_remainder, held_r);
`endif
            end
            if (out_ready) begin
              chk("quotient", out_quotient, sb[0].q);
`ifdef DIV5_REM_OUT_EN
              chk("remainder", out_remainder, sb[0].r);
`endif
              $display("deliver quotient=%0d expected=%0d (cycle %0d)", out_quotient, sb[0].q, cyc);
              void'(sb.pop_front());
              seen = 0;
              expect_idle = 1;
            end
          end
        end else begin
          seen = 0;
        end
      end
    end
  end

  // Offer one dividend and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [W-1:0] d);
    int k = 0;
    in_valid    = 1'b1;
    in_dividend = d;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_dividend = $urandom;
  endtask

  // Wait until all accepted work has been delivered.
  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0 || busy) chk("drain_timeout", 0, 1);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] directed [5];
    directed[0] = 32'd100;
    directed[1] = 32'd7;
    directed[2] = 32'd0;
    directed[3] = 32'hFFFF_FFFF;
    directed[4] = 32'hFFFF_FFFE;

    rst = 1'b1; in_valid = 1'b0; in_dividend = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, held through a few idle cycles.
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_quotient", out_quotient, 0);
`ifdef DIV5_REM_OUT_EN
      chk("reset_remainder", out_remainder, 0);
`endif
    end
    @(posedge clk); #1;

    // Directed values including the extremes.
    foreach (directed[i]) begin
      send(directed[i]);
      wait_drain();
    end

    // Back-to-back with no gaps: one result per 18 cycles.
    burst_mode = 1; prev_acc = -1;
    for (int i = 0; i < 4; i++) send($urandom);
    wait_drain();
    burst_mode = 0;

    // Back-pressure: result held 5 cycles, new in_valid ignored.
    out_ready = 1'b0;
    send(32'd1234);
    begin
      int k = 0;
      while (!out_valid && k < 100) begin @(negedge clk); k++; end
      chk("bp_out_valid_seen", out_valid, 1);
    end
    in_valid = 1'b1; in_dividend = 32'd999;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_quotient", out_quotient, 246);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain();

    // Reset mid-run after 8 steps.
    send(32'h1234_5678);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_quotient", out_quotient, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("no_valid_after_rst", out_valid, 0);
    end
    @(posedge clk); #1;
    send(32'd10);
    wait_drain();

    // Random dividends with random input gaps and out_ready stalls.
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 7))
        0:       d = 32'hFFFF_FFFF - W'($urandom_range(0, 9));
        1:       d = W'($urandom_range(0, 30));
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send(d);
    end
    wait_drain();
    rand_ready = 0;
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
